irq_pending_latch: RTL and testbench

- Sequential request-capture stage that sits directly upstream of the 8-to-3 priority encoding path.
- Edge-detects 8 request lines and holds them in a pending register.
- Applies a mask and presents the highest-priority unmasked pending request as a 3-bit id, using a valid/ack handshake.
- Bit 7 is highest priority and bit 0 lowest, the same ordering as the downstream encoder.

---
 rtl/irq_pending_latch.sv | 108 ++++++++++
 tb/tb_irq_pending_latch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Edge-detecting interrupt pending latch with mask and a valid/ack presentation handshake.
// Bit N-1 has the highest priority, matching the downstream priority encoder.
module irq_pending_latch #(
  parameter int unsigned N   = 8,
  parameter int unsigned IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_in,
  input  logic [N-1:0]   mask,
  input  logic           irq_ack,
  input  logic           clr_ovr,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending,
  output logic           overrun
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e         state_q;
  logic [N-1:0]   req_prev_q;
  logic [N-1:0]   pending_q, pending_d;
  logic           valid_q;
  logic [IDW-1:0] id_q;
  logic           ovr_q, ovr_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   ack_bit;
  logic [N-1:0]   elig;
  logic           ack_acc;
  logic [IDW-1:0] hi_idx;

  assign rise    = req_in & ~req_prev_q;
  assign ack_acc = (state_q == StPresent) && irq_ack;
  assign elig    = pending_q & ~mask;

  always_comb begin
    ack_bit = '0;
    if (ack_acc) ack_bit[id_q] = 1'b1;
  end

  // A new rise on the bit being acked keeps it pending and is not an overrun.
  always_comb begin
    pending_d = rise | (pending_q & ~ack_bit);
    if (|(rise & pending_q & ~ack_bit)) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Ascending scan so the highest set bit wins.
  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (elig[i]) hi_idx = IDW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prev_q <= '0;
      pending_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      req_prev_q <= req_in;
      pending_q  <= pending_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|elig) begin
            state_q <= StPresent;
            valid_q <= 1'b1;
            id_q    <= hi_idx;
          end
        end
        StPresent: begin
          if (irq_ack) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: one task per scenario, hand-computed expectations.
module tb_irq_pending_latch;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       clr_ovr;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  irq_pending_latch #(.N(8), .IDW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .clr_ovr   (clr_ovr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 8'h00; mask = 8'h00; irq_ack = 1'b0; clr_ovr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if ({irq_valid, irq_id, pending, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b id=%0d p=%h o=%b exp all zero",
               irq_valid, irq_id, pending, overrun);
    end
  endtask

  task automatic test_single();
    req_in = 8'h01;
    tick();
    req_in = 8'h00;
    total++;
    if (pending !== 8'h01 || irq_valid !== 1'b0) begin
      bad++; $display("FAIL single_latch got p=%h v=%b exp p=01 v=0", pending, irq_valid);
    end
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin
      bad++; $display("FAIL single_present got v=%b id=%0d exp v=1 id=0", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++;
    if (irq_valid !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL single_ack got v=%b p=%h exp v=0 p=00", irq_valid, pending);
    end
  endtask

  task automatic test_same_cycle();
    req_in = 8'h24;
    tick();
    req_in = 8'h00;
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin
      bad++; $display("FAIL same_first got v=%b id=%0d exp v=1 id=5", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++;
    if (irq_valid !== 1'b0 || pending !== 8'h04) begin
      bad++; $display("FAIL same_idle got v=%b p=%h exp v=0 p=04", irq_valid, pending);
    end
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin
      bad++; $display("FAIL same_second got v=%b id=%0d exp v=1 id=2", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++;
    if (pending !== 8'h00 || irq_valid !== 1'b0) begin
      bad++; $display("FAIL same_done got p=%h v=%b exp p=00 v=0", pending, irq_valid);
    end
  endtask

  task automatic test_priority_hold();
    req_in = 8'h04;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h80;
    tick();
    req_in = 8'h00;
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd2 || pending !== 8'h84) begin
      bad++;
      $display("FAIL hold_nopreempt got v=%b id=%0d p=%h exp v=1 id=2 p=84",
               irq_valid, irq_id, pending);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin
      bad++; $display("FAIL hold_next got v=%b id=%0d exp v=1 id=7", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_mask();
    mask = 8'h80; req_in = 8'h81;
    tick();
    req_in = 8'h00;
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin
      bad++; $display("FAIL mask_present got v=%b id=%0d exp v=1 id=0", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    total++;
    if (irq_valid !== 1'b0 || pending !== 8'h80) begin
      bad++; $display("FAIL mask_blocked got v=%b p=%h exp v=0 p=80", irq_valid, pending);
    end
    // Ack with nothing presented must be ignored.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++;
    if (pending !== 8'h80 || irq_valid !== 1'b0) begin
      bad++; $display("FAIL ack_ignored got p=%h v=%b exp p=80 v=0", pending, irq_valid);
    end
    mask = 8'h00;
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin
      bad++; $display("FAIL mask_unmask got v=%b id=%0d exp v=1 id=7", irq_valid, irq_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_overrun();
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h08;
    tick();
    req_in = 8'h00;
    total++;
    if (overrun !== 1'b1 || pending !== 8'h08) begin
      bad++; $display("FAIL ovr_set got o=%b p=%h exp o=1 p=08", overrun, pending);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_clear got o=%b exp o=0", overrun);
    end
    req_in = 8'h08; irq_ack = 1'b1;
    tick();
    req_in = 8'h00; irq_ack = 1'b0;
    total++;
    if (overrun !== 1'b0 || pending !== 8'h08 || irq_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovr_rise_ack got o=%b p=%h v=%b exp o=0 p=08 v=0",
               overrun, pending, irq_valid);
    end
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin
      bad++; $display("FAIL ovr_represent got v=%b id=%0d exp v=1 id=3", irq_valid, irq_id);
    end
    req_in = 8'h08; clr_ovr = 1'b1;
    tick();
    req_in = 8'h00;
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_set_beats_clr got o=%b exp o=1", overrun);
    end
    tick();
    clr_ovr = 1'b0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++;
    if (overrun !== 1'b0 || pending !== 8'h00) begin
      bad++; $display("FAIL ovr_final got o=%b p=%h exp o=0 p=00", overrun, pending);
    end
  endtask

  task automatic test_reset_mid();
    req_in = 8'h10;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h10;
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd4 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_setup got v=%b id=%0d o=%b exp v=1 id=4 o=1",
               irq_valid, irq_id, overrun);
    end
    rst = 1'b1;
    #2;
    total++;
    if ({irq_valid, irq_id, pending, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL rstmid_async got v=%b id=%0d p=%h o=%b exp all zero",
               irq_valid, irq_id, pending, overrun);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (irq_valid !== 1'b0 || pending !== 8'h10) begin
      bad++; $display("FAIL rstmid_edge1 got v=%b p=%h exp v=0 p=10", irq_valid, pending);
    end
    tick();
    total++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin
      bad++; $display("FAIL rstmid_edge2 got v=%b id=%0d exp v=1 id=4", irq_valid, irq_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_priority_hold();
    test_mask();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
